// File: rtl/fifo_pkg.sv
// Shared constants and width/legality helpers for the synchronous flag FIFO.
package fifo_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_DEPTH  = 16;

    function automatic int unsigned addr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // One extra bit so the count can represent DEPTH itself.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit params_ok(input int unsigned data_w, input int unsigned depth,
                                     input int unsigned af_level, input int unsigned ae_level);
        return (data_w >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
               (af_level >= 1) && (af_level <= depth) && (ae_level <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_sync_flags_if.sv
// Producer/consumer-side signal bundle for fifo_sync_flags; the FIFO uses the slave modport.
interface fifo_sync_flags_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned DEPTH  = DEFAULT_DEPTH
);
    localparam int unsigned CNT_W = cnt_w(DEPTH);

    logic              wr_en;
    logic [DATA_W-1:0] data_in;
    logic              rd_en;
    logic              clr_err;
    logic [DATA_W-1:0] data_out;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, data_in, rd_en, clr_err,
        input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr_en, data_in, rd_en, clr_err,
        output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage array. Read port is asynchronous when FIFO_FWFT_EN is defined,
// registered otherwise.
module fifo_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef FIFO_FWFT_EN
    assign rd_data = mem[rd_addr];
`else
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end
`endif

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, almost flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word fall-through reads; default is registered read.
module fifo_sync_flags
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned DEPTH    = DEFAULT_DEPTH,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input logic              clk,
    input logic              rst,
    fifo_sync_flags_if.slave bus
);

    localparam int unsigned ADDR_W = addr_w(DEPTH);
    localparam int unsigned CNT_W  = cnt_w(DEPTH);

    if (!params_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $error("fifo_sync_flags: illegal parameter combination");
    end

    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q, underflow_q;
    logic              full, empty, wr_ok, rd_ok;
    logic [DATA_W-1:0] ram_rd_data;
    logic [DATA_W-1:0] data_out;

    always_comb begin
        full  = (count_q == CNT_W'(DEPTH));
        empty = (count_q == '0);
        wr_ok = bus.wr_en & ~full;
        rd_ok = bus.rd_en & ~empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            // A new error event wins over a same-cycle clear.
            overflow_q  <= (bus.wr_en & full)  | (overflow_q  & ~bus.clr_err);
            underflow_q <= (bus.rd_en & empty) | (underflow_q & ~bus.clr_err);
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.data_in),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

`ifdef FIFO_FWFT_EN
    assign data_out = empty ? '0 : ram_rd_data;
`else
    // The RAM samples mem[rd_ptr] every edge; only the sample taken on an accepted read is
    // presented, otherwise the previous output is held.
    logic              rd_fire_q;
    logic [DATA_W-1:0] dout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_fire_q <= 1'b0;
            dout_q    <= '0;
        end else begin
            rd_fire_q <= rd_ok;
            dout_q    <= data_out;
        end
    end

    assign data_out = rd_fire_q ? ram_rd_data : dout_q;
`endif

    assign bus.data_out     = data_out;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Randomized plus directed bench for fifo_sync_flags against a queue-based reference model.
module tb_fifo_sync_flags;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned AF     = 14;
    localparam int unsigned AE     = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_sync_flags_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    fifo_sync_flags #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_dout = '0;
    bit                m_ovf  = 1'b0;
    bit                m_udf  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [DATA_W-1:0] exp_dout;
        int n;
        n = q.size();
`ifdef FIFO_FWFT_EN
        exp_dout = (n != 0) ? q[0] : '0;
`else
        exp_dout = m_dout;
`endif
        check({tag, ".count"}, 64'(bus.count), 64'(n));
        check({tag, ".full"}, 64'(bus.full), 64'(n == DEPTH));
        check({tag, ".empty"}, 64'(bus.empty), 64'(n == 0));
        check({tag, ".afull"}, 64'(bus.almost_full), 64'(n >= AF));
        check({tag, ".aempty"}, 64'(bus.almost_empty), 64'(n <= AE));
        check({tag, ".ovf"}, 64'(bus.overflow), 64'(m_ovf));
        check({tag, ".udf"}, 64'(bus.underflow), 64'(m_udf));
        check({tag, ".dout"}, 64'(bus.data_out), 64'(exp_dout));
    endtask

    // One clock: drive inputs away from the edge, advance the model, check after the edge.
    task automatic cyc(input string tag, input bit r, input bit w, input logic [DATA_W-1:0] d,
                       input bit rd, input bit c);
        bit was_full, was_empty;
        @(negedge clk);
        rst         = r;
        bus.wr_en   = w;
        bus.data_in = d;
        bus.rd_en   = rd;
        bus.clr_err = c;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (r) begin
            q.delete();
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
            m_dout = '0;
        end else begin
            if (rd && !was_empty) m_dout = q.pop_front();
            if (w && !was_full) q.push_back(d);
            m_ovf = (w && was_full) || (m_ovf && !c);
            m_udf = (rd && was_empty) || (m_udf && !c);
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        int p_wr, p_rd;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
        bus.data_in = '0;

        cyc("reset", 1, 0, '0, 0, 0);
        cyc("reset2", 1, 1, 32'h55, 1, 1);

        // Fill then overflow at full.
        for (int i = 0; i < 16; i++) cyc("fill", 0, 1, DATA_W'(i), 0, 0);
        check("fill_full_const", 64'(bus.full), 64'(1));
        cyc("ovf_write", 0, 1, 32'hDEAD, 0, 0);
        check("ovf_const", 64'(bus.overflow), 64'(1));
        cyc("clr_err", 0, 0, '0, 0, 1);
        for (int i = 0; i < 16; i++) cyc("drain", 0, 0, '0, 1, 0);
        cyc("drain_tail", 0, 0, '0, 0, 0);

        // Simultaneous read/write while empty, then read it back.
        cyc("udf_rw", 0, 1, 32'h2A, 1, 0);
        check("udf_count_const", 64'(bus.count), 64'(1));
        cyc("udf_read", 0, 0, '0, 1, 1);
        cyc("udf_tail", 0, 0, '0, 0, 0);

        // Wrap-around at constant occupancy.
        for (int i = 0; i < 5; i++) cyc("wrap_pre", 0, 1, DATA_W'(32'h100 + i), 0, 0);
        for (int i = 0; i < 40; i++) cyc("wrap", 0, 1, DATA_W'(32'h200 + i), 1, 0);

        // Full with simultaneous read/write.
        for (int i = 0; i < 11; i++) cyc("refill", 0, 1, DATA_W'(32'h300 + i), 0, 0);
        cyc("full_rw", 0, 1, 32'hBEEF, 1, 0);
        check("full_rw_count_const", 64'(bus.count), 64'(15));

        // Reset mid-stream then a fresh word.
        cyc("mid_rst", 1, 0, '0, 0, 0);
        for (int i = 0; i < 7; i++) cyc("pre_rst", 0, 1, DATA_W'(32'h400 + i), 0, 0);
        cyc("mid_rst2", 1, 1, 32'h77, 1, 0);
        cyc("post_rst_w", 0, 1, 32'h3F, 0, 0);
        cyc("post_rst_r", 0, 0, '0, 1, 0);
        cyc("post_rst_t", 0, 0, '0, 0, 0);

        // Random phases with varying bias to sweep full/empty boundaries.
        for (int ph = 0; ph < 20; ph++) begin
            p_wr = $urandom_range(15, 85);
            p_rd = $urandom_range(15, 85);
            for (int i = 0; i < 100; i++) begin
                cyc("rand",
                    ($urandom_range(0, 299) == 0),
                    ($urandom_range(0, 99) < p_wr),
                    DATA_W'($urandom),
                    ($urandom_range(0, 99) < p_rd),
                    ($urandom_range(0, 9) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
- Parametrised single-clock synchronous FIFO. Next generation of the team's basic FIFO.
- Adds configurable data width and depth, an occupancy count, almost-full and almost-empty thresholds, and sticky overflow/underflow error flags with explicit clear.
- Sits between producer and consumer blocks in the same clock domain. Flags are used for upstream back-pressure and downstream burst scheduling.

Parameters:
- DATA_W, 32: data word width in bits, ≥1.
- DEPTH, 16: number of entries; power of two, ≥2.
- AF_LEVEL, DEPTH-2: almost_full asserts when count ≥ AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count ≤ AE_LEVEL; legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- data_in  in  DATA_W  write data, sampled on an accepted write.
- rd_en  in  1  read request (acknowledge in FWFT mode).
- data_out  out  DATA_W  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- clr_err  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset (rst=1 at edge): wr_ptr, rd_ptr and count = 0; empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, data_out=0. Storage contents are not cleared.
- Reset mid-operation discards all stored entries. rst has priority over every other input.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- wr_ok = wr_en & ~full; rd_ok = rd_en & ~empty. Both are evaluated from registered state before the edge.
- wr_ok: store data_in at mem[wr_ptr], increment wr_ptr.
- rd_ok: increment rd_ptr.
- Count update: +1 if wr_ok only; -1 if rd_ok only; unchanged if both or neither.
- Simultaneous wr_en & rd_en when full: read accepted, write rejected, overflow set. Count drops to DEPTH-1.
- Simultaneous wr_en & rd_en when empty: write accepted, read rejected, underflow set. Count becomes 1.
- Simultaneous wr_en & rd_en otherwise: both accepted, count unchanged.
- Standard mode: data_out <= mem[rd_ptr] on the rd_ok edge, so data is valid the cycle after the read is accepted. data_out holds its value when no read is accepted.
- Flags are combinational decodes of the registered count, so all flags change on the same edge as count.
- overflow sets on wr_en & full; underflow sets on rd_en & empty. Both stay set until clr_err or rst.
- If a set condition and clr_err occur in the same cycle, set wins.
- Rejected operations change no pointer, count or storage.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined (first-word fall-through):
  - data_out is driven combinationally from mem[rd_ptr] whenever empty=0, and is 0 when empty.
  - A written word appears on data_out the cycle after its write edge.
  - rd_en acknowledges the presented word and advances to the next entry.
  - Read latency is 0.
- Undefined: standard registered-read behaviour as described above. Read latency is 1.
- Pointer, count, flag and error behaviour are identical in both modes.

Decomposition:
- Package fifo_pkg: ADDR_W/CNT_W derivation helpers (clog2-based), default DATA_W/DEPTH constants, and a parameter-legality check macro/function.
- One sub-module, fifo_ram: a simple dual-port array with synchronous write and read.
  - Read is asynchronous under FIFO_FWFT_EN, registered otherwise.
  - Ports: clk, wr_en, wr_addr, wr_data, rd_addr, rd_data.
- Top-level fifo_sync_flags owns pointers, count, flags and error logic.

Test Plan:
- Fill/drain (DATA_W=32, DEPTH=16, AF=14, AE=2):
  - Write 0x00..0x0F → full=1 after 16th write; almost_full rises at count=14.
  - Read 16 words → data_out sequence 0x00..0x0F in order; empty=1 at end; almost_empty rises at count=2.
- Overflow: at full, write 0xDEAD → overflow=1, count stays 16, next read returns 0x00. clr_err → overflow=0.
- Underflow plus simultaneous write at empty: rd_en=wr_en=1 with data 0x2A → underflow=1, count=1. Next read returns 0x2A.
- Wrap-around: 40 interleaved write/read pairs with count held at 5 → no data loss; pointers wrap ≥2 times; count stays 5.
- Full with simultaneous read/write: read accepted, write rejected, overflow=1, count=15.
- Reset mid-stream: write 7 words, assert rst 1 cycle → count=0, empty=1, flags cleared. Next write 0x3F reads back as 0x3F.
- FWFT build: write 0x2A → data_out=0x2A one cycle later with rd_en=0; rd_en pulse → empty=1, data_out=0.
